// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - rhythm-game hit judge: pad conditioning, slot FSM and score keeping
// Buttons are synchronized and debounced; verdicts register one cycle after the press pulse.
module hit_judge #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [1:0]  judge_result,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [15:0] score,
  output logic [7:0]  miss_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE, S_FIN} state_t;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_MISS  = 2'd2;
  localparam logic [1:0] RES_WRONG = 2'd3;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {blue_button, red_button};

  // Index 0 is the red pad, index 1 the blue pad.
  for (genvar g = 0; g < 2; g++) begin : g_pad
    logic        r_sync1;
    logic        r_sync2;
    logic        r_deb;
    logic        r_deb_d;
    logic [19:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_cnt   <= 20'd0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        r_deb_d <= r_deb;
        if (r_sync2 == r_deb) begin
          r_cnt <= 20'd0;
        end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
          r_deb <= r_sync2;
          r_cnt <= 20'd0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end
    end

    assign w_press[g] = r_deb & ~r_deb_d;
  end

  logic [2:0]  r_offset_prev;
  state_t      r_state;
  logic        r_delete;
  logic [1:0]  r_result;
  logic [7:0]  r_combo;
  logic [7:0]  r_max_combo;
  logic [15:0] r_score;
  logic [7:0]  r_miss;

  logic        w_adv;
  logic        w_note;
  logic        w_any_press;
  logic        w_hit;
  logic [7:0]  w_combo_inc;
  logic [7:0]  w_miss_inc;
  logic [16:0] w_score_sum;
  logic [15:0] w_score_next;

  assign w_adv       = (r_offset_prev == 3'd6) && (offset == 3'd0);
  assign w_note      = note_R_judge | note_B_judge;
  assign w_any_press = |w_press;
  // A simultaneous red+blue press never counts as a hit, even with both notes present.
  assign w_hit       = (w_press[0] & ~w_press[1] & note_R_judge) |
                       (w_press[1] & ~w_press[0] & note_B_judge);
  assign w_combo_inc  = (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;
  assign w_miss_inc   = (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;
  assign w_score_sum  = {1'b0, r_score} + ((r_combo < 8'd10) ? 17'd1 : 17'd2);
  assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_offset_prev <= 3'd0;
      r_state       <= S_IDLE;
      r_delete      <= 1'b0;
      r_result      <= RES_NONE;
      r_combo       <= 8'd0;
      r_max_combo   <= 8'd0;
      r_score       <= 16'd0;
      r_miss        <= 8'd0;
    end else begin
      r_offset_prev <= offset;
      r_delete      <= 1'b0;
      if (finish) begin
        r_state <= S_FIN;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_note) r_state <= S_ARMED;
          end
          S_ARMED: begin
            // A press wins over a coincident slot advance.
            if (w_any_press) begin
              r_state <= S_DONE;
              if (w_hit) begin
                r_delete <= 1'b1;
                r_result <= RES_HIT;
                r_score  <= w_score_next;
                r_combo  <= w_combo_inc;
                if (w_combo_inc > r_max_combo) r_max_combo <= w_combo_inc;
              end else begin
                r_result <= RES_WRONG;
                r_combo  <= 8'd0;
                r_miss   <= w_miss_inc;
              end
            end else if (w_adv) begin
              r_result <= RES_MISS;
              r_combo  <= 8'd0;
              r_miss   <= w_miss_inc;
              r_state  <= w_note ? S_ARMED : S_IDLE;
            end
          end
          S_DONE: begin
            if (w_adv) r_state <= w_note ? S_ARMED : S_IDLE;
          end
          S_FIN: begin
            r_state     <= S_IDLE;
            r_result    <= RES_NONE;
            r_combo     <= 8'd0;
            r_max_combo <= 8'd0;
            r_score     <= 16'd0;
            r_miss      <= 8'd0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign delete       = r_delete;
  assign judge_result = r_result;
  assign combo        = r_combo;
  assign max_combo    = r_max_combo;
  assign score        = r_score;
  assign miss_count   = r_miss;

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - directed self-checking bench for hit_judge
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        red_button = 1'b0;
  logic        blue_button = 1'b0;
  logic        note_R_judge = 1'b0;
  logic        note_B_judge = 1'b0;
  logic [2:0]  offset = 3'd0;
  logic        finish = 1'b0;
  logic        delete;
  logic [1:0]  judge_result;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [15:0] score;
  logic [7:0]  miss_count;

  int n_checks = 0;
  int n_fail = 0;

  hit_judge #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk(clk), .rst(rst),
    .red_button(red_button), .blue_button(blue_button),
    .note_R_judge(note_R_judge), .note_B_judge(note_B_judge),
    .offset(offset), .finish(finish),
    .delete(delete), .judge_result(judge_result),
    .combo(combo), .max_combo(max_combo),
    .score(score), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0; red_button = 1'b0; blue_button = 1'b0;
    note_R_judge = 1'b0; note_B_judge = 1'b0; offset = 3'd0; finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n, output int dels);
    dels = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (delete) dels++;
    end
  endtask

  task automatic press_red(input int hold, output int dels);
    int d;
    red_button = 1'b1;
    wait_cycles(hold, dels);
    red_button = 1'b0;
    wait_cycles(10, d);
    dels += d;
  endtask

  task automatic advance(output int dels);
    int d;
    offset = 3'd6;
    wait_cycles(1, dels);
    offset = 3'd0;
    wait_cycles(2, d);
    dels += d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({delete, judge_result, combo, max_combo, score, miss_count} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got del=%0b res=%0d combo=%0d max=%0d score=%0d miss=%0d, expected all 0",
               delete, judge_result, combo, max_combo, score, miss_count);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    int dels;
    apply_reset();
    note_R_judge = 1'b1;
    wait_cycles(2, dels);
    press_red(10, dels);
    n_checks++;
    if (dels !== 1) begin n_fail++; $display("FAIL hit_delete_count: got %0d expected 1", dels); end
    n_checks++;
    if (judge_result !== 2'd1) begin n_fail++; $display("FAIL hit_result: got %0d expected 1", judge_result); end
    n_checks++;
    if (combo !== 8'd1) begin n_fail++; $display("FAIL hit_combo: got %0d expected 1", combo); end
    n_checks++;
    if (score !== 16'd1) begin n_fail++; $display("FAIL hit_score: got %0d expected 1", score); end
    press_red(10, dels);
    n_checks++;
    if (dels !== 0) begin n_fail++; $display("FAIL done_press_delete: got %0d expected 0", dels); end
    n_checks++;
    if (combo !== 8'd1 || score !== 16'd1) begin
      n_fail++; $display("FAIL done_press_counters: got combo=%0d score=%0d expected 1/1", combo, score);
    end
  endtask

  task automatic test_combo();
    int dels;
    int total;
    apply_reset();
    note_R_judge = 1'b1;
    wait_cycles(2, dels);
    total = 0;
    for (int i = 0; i < 12; i++) begin
      press_red(10, dels);
      total += dels;
      advance(dels);
      total += dels;
    end
    n_checks++;
    if (total !== 12) begin n_fail++; $display("FAIL combo_delete_count: got %0d expected 12", total); end
    n_checks++;
    if (combo !== 8'd12) begin n_fail++; $display("FAIL combo_value: got %0d expected 12", combo); end
    n_checks++;
    if (max_combo !== 8'd12) begin n_fail++; $display("FAIL combo_max: got %0d expected 12", max_combo); end
    n_checks++;
    if (score !== 16'd14) begin n_fail++; $display("FAIL combo_score: got %0d expected 14", score); end
    n_checks++;
    if (miss_count !== 8'd0) begin n_fail++; $display("FAIL combo_miss: got %0d expected 0", miss_count); end
  endtask

  task automatic test_finish();
    int dels;
    finish = 1'b1;
    wait_cycles(1, dels);
    press_red(10, dels);
    n_checks++;
    if (dels !== 0) begin n_fail++; $display("FAIL fin_delete: got %0d expected 0", dels); end
    n_checks++;
    if (score !== 16'd14 || combo !== 8'd12 || max_combo !== 8'd12 || judge_result !== 2'd1 || miss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL fin_hold: got score=%0d combo=%0d max=%0d res=%0d miss=%0d expected 14/12/12/1/0",
               score, combo, max_combo, judge_result, miss_count);
    end
    finish = 1'b0;
    wait_cycles(2, dels);
    n_checks++;
    if ({judge_result, combo, max_combo, score, miss_count} !== 42'd0) begin
      n_fail++;
      $display("FAIL fin_clear: got res=%0d combo=%0d max=%0d score=%0d miss=%0d expected all 0",
               judge_result, combo, max_combo, score, miss_count);
    end
  endtask

  task automatic test_wrong();
    int dels;
    apply_reset();
    note_B_judge = 1'b1;
    wait_cycles(2, dels);
    press_red(10, dels);
    n_checks++;
    if (dels !== 0) begin n_fail++; $display("FAIL wrong_delete: got %0d expected 0", dels); end
    n_checks++;
    if (judge_result !== 2'd3) begin n_fail++; $display("FAIL wrong_result: got %0d expected 3", judge_result); end
    n_checks++;
    if (combo !== 8'd0 || miss_count !== 8'd1 || score !== 16'd0) begin
      n_fail++; $display("FAIL wrong_counters: got combo=%0d miss=%0d score=%0d expected 0/1/0", combo, miss_count, score);
    end
  endtask

  task automatic test_miss();
    int dels;
    apply_reset();
    note_R_judge = 1'b1;
    wait_cycles(2, dels);
    press_red(10, dels);
    advance(dels);
    advance(dels);
    n_checks++;
    if (dels !== 0) begin n_fail++; $display("FAIL miss_delete: got %0d expected 0", dels); end
    n_checks++;
    if (judge_result !== 2'd2) begin n_fail++; $display("FAIL miss_result: got %0d expected 2", judge_result); end
    n_checks++;
    if (combo !== 8'd0 || miss_count !== 8'd1) begin
      n_fail++; $display("FAIL miss_counters: got combo=%0d miss=%0d expected 0/1", combo, miss_count);
    end
    n_checks++;
    if (score !== 16'd1 || max_combo !== 8'd1) begin
      n_fail++; $display("FAIL miss_score_kept: got score=%0d max=%0d expected 1/1", score, max_combo);
    end
  endtask

  task automatic test_bounce();
    int dels;
    int d;
    apply_reset();
    note_R_judge = 1'b1;
    wait_cycles(2, dels);
    dels = 0;
    for (int i = 0; i < 10; i++) begin
      red_button = ~red_button;
      wait_cycles(2, d);
      dels += d;
    end
    red_button = 1'b0;
    wait_cycles(10, d);
    dels += d;
    n_checks++;
    if (dels !== 0) begin n_fail++; $display("FAIL bounce_delete: got %0d expected 0", dels); end
    n_checks++;
    if (judge_result !== 2'd0 || combo !== 8'd0 || miss_count !== 8'd0) begin
      n_fail++; $display("FAIL bounce_state: got res=%0d combo=%0d miss=%0d expected 0/0/0", judge_result, combo, miss_count);
    end
  endtask

  task automatic test_reset_armed();
    int dels;
    apply_reset();
    note_R_judge = 1'b1;
    wait_cycles(2, dels);
    press_red(10, dels);
    advance(dels);
    red_button = 1'b1;
    wait_cycles(4, dels);
    rst = 1'b0;
    red_button = 1'b0;
    wait_cycles(2, dels);
    n_checks++;
    if ({delete, judge_result, combo, max_combo, score, miss_count} !== 43'd0) begin
      n_fail++;
      $display("FAIL armed_reset_outputs: got del=%0b res=%0d combo=%0d max=%0d score=%0d miss=%0d expected all 0",
               delete, judge_result, combo, max_combo, score, miss_count);
    end
    rst = 1'b1;
    wait_cycles(12, dels);
    n_checks++;
    if (dels !== 0 || combo !== 8'd0) begin
      n_fail++; $display("FAIL armed_reset_release: got dels=%0d combo=%0d expected 0/0", dels, combo);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_combo();
    test_finish();
    test_wrong();
    test_miss();
    test_bounce();
    test_reset_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd500000, meaning the number of stable cycles a button must hold before its level is accepted.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port red_button, input, 1, raw asynchronous red pad (active-high).
REQ-005 SHALL have port blue_button, input, 1, raw asynchronous blue pad (active-high).
REQ-006 SHALL have port note_R_judge, input, 1, red note present in the judge slot.
REQ-007 SHALL have port note_B_judge, input, 1, blue note present in the judge slot.
REQ-008 SHALL have port offset, input, 3, shifter pixel counter; sequence 0..6, wraps 6->0 when lanes advance.
REQ-009 SHALL have port finish, input, 1, song-end indication.
REQ-010 SHALL have port delete, output, 1, one-cycle pulse that clears the judged note from the shifter.
REQ-011 SHALL have port judge_result, output, 2, last verdict: 0 NONE, 1 HIT, 2 MISS, 3 WRONG.
REQ-012 SHALL have port combo, output, 8, current consecutive-hit count.
REQ-013 SHALL have port max_combo, output, 8, highest combo this song.
REQ-014 SHALL have port score, output, 16, accumulated score.
REQ-015 SHALL have port miss_count, output, 8, misses plus wrong presses this song.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-017 SHALL derive press_R/press_B as one-cycle rising-edge pulses of the debounced levels.
REQ-018 SHALL detect a slot advance, adv, in any cycle where the registered previous offset == 6 and offset == 0.
REQ-019 SHALL implement FSM states IDLE, ARMED, DONE, FIN.
- IDLE -> ARMED when (note_R_judge | note_B_judge) == 1.
- ARMED -> DONE on a press (REQ-020/021).
- ARMED -> ARMED on adv with a note still present; MISS is recorded first.
- ARMED -> IDLE on adv with no note present; MISS is recorded first.
- DONE -> ARMED on adv with a note present; otherwise DONE -> IDLE on adv.
- Any state -> FIN when finish == 1.
- FIN -> IDLE when finish falls.
REQ-020 In ARMED, press matching the present note color (press_R & note_R_judge, or press_B & note_B_judge), with the other press low: HIT.
REQ-021 In ARMED, press_R & press_B in the same cycle, or a press of the non-matching color only: WRONG, no delete.
REQ-022 HIT SHALL, in the cycle after the press pulse:
- assert delete for exactly 1 cycle;
- set judge_result=1;
- add to score: 1 if combo (pre-increment) < 10, else 2; saturate at 16'hFFFF;
- increment combo, saturating at 255;
- set max_combo = max(max_combo, new combo).
REQ-023 MISS (ARMED at adv, no press) and WRONG SHALL, one cycle later:
- set combo=0;
- increment miss_count, saturating at 255;
- set judge_result to 2 or 3 respectively;
- leave score unchanged.
REQ-024 Presses in IDLE, DONE or FIN SHALL be ignored: no delete, no counter change.
REQ-025 A press and adv in the same ARMED cycle SHALL be judged as the press; no MISS.
REQ-026 delete SHALL never assert on two consecutive cycles and at most once per slot period.
REQ-027 In FIN, score, combo, max_combo, miss_count and judge_result SHALL hold their values for display.
REQ-028 The finish falling edge SHALL clear score, combo, max_combo, miss_count and judge_result to 0.

Reset
REQ-029 With rst==0 at a clk edge:
- state=IDLE;
- delete=0, judge_result=0, combo=0, max_combo=0, score=0, miss_count=0;
- synchronizers, debounce counters and debounced levels = 0; offset register = 0.
REQ-030 A reset asserted mid-ARMED SHALL discard any pending verdict; no delete follows reset release.

Verification (DEBOUNCE_CYCLES overridden to 4)
REQ-031 The bench SHALL cover the following scenarios:
- note_R_judge=1, clean red press held for 10 cycles -> exactly one delete pulse, judge_result=1, combo=1, score=1.
- 12 consecutive red hits -> combo=12, max_combo=12, score=10*1+2*2=14.
- note_B_judge=1, red press -> delete stays 0, judge_result=3, combo=0, miss_count=1.
- note_R_judge=1, no press across the offset 6->0 advance -> judge_result=2, combo=0, miss_count=1, score unchanged.
- red pad toggling every 2 cycles for 20 cycles with a note present -> no press accepted, delete stays 0.
- finish=1 with score=14 -> values held; finish falls -> all counters 0; rst low during ARMED -> all outputs 0 and no delete.
